// File: rtl/mem_arbiter.sv
// Shares one word-granular memory port between the icache and the dcache.
// A grant is held for the whole burst and handed off round-robin on ties.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    input  logic [31:0] i_imem_addr,
    input  logic        i_imem_ren,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    output logic        o_imem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_valid,
    output logic [1:0]  o_grant
);

    // state   | meaning
    // IDLE    | no owner, downstream port driven to 0
    // GRANT_I | icache owns the memory port
    // GRANT_D | dcache owns the memory port
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;

    logic own_i, own_d;
    logic req_i, req_d;
    logic own_req;
    logic cnt_zero, cnt_full;
    logic own_ready;
    logic acc_rd;
    logic rsp;
    logic rel;

    always_comb begin
        own_i     = (state_q == GRANT_I);
        own_d     = (state_q == GRANT_D);
        req_i     = i_imem_ren;
        req_d     = i_dmem_ren | i_dmem_wen;
        own_req   = (own_i & req_i) | (own_d & req_d);
        cnt_zero  = (cnt_q == '0);
        cnt_full  = (cnt_q == CNT_MAX);
        own_ready = i_mem_ready && (cnt_q < CNT_MAX);
        acc_rd    = own_ready && ((own_i && i_imem_ren) || (own_d && i_dmem_ren));
        // a response with nothing outstanding is a stray and is dropped
        rsp       = i_mem_valid && !cnt_zero;
        rel       = !own_req && cnt_zero && !i_mem_valid;
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        if (state_q == IDLE || rel) begin
            if (req_i && req_d) begin
                state_d  = last_d_q ? GRANT_I : GRANT_D;
                last_d_d = ~last_d_q;
            end else if (req_i) begin
                state_d  = GRANT_I;
                last_d_d = 1'b0;
            end else if (req_d) begin
                state_d  = GRANT_D;
                last_d_d = 1'b1;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (acc_rd && !rsp) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!acc_rd && rsp) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        o_mem_addr   = '0;
        o_mem_ren    = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_wdata  = '0;
        o_imem_ready = 1'b0;
        o_imem_rdata = '0;
        o_imem_valid = 1'b0;
        o_dmem_ready = 1'b0;
        o_dmem_rdata = '0;
        o_dmem_valid = 1'b0;
        o_grant      = state_q;
        if (own_i) begin
            o_mem_addr   = i_imem_addr;
            o_mem_ren    = i_imem_ren && !cnt_full;
            o_imem_ready = own_ready;
            o_imem_rdata = i_mem_rdata;
            o_imem_valid = rsp;
        end else if (own_d) begin
            o_mem_addr   = i_dmem_addr;
            o_mem_ren    = i_dmem_ren && !cnt_full;
            o_mem_wen    = i_dmem_wen && !cnt_full;
            o_mem_wdata  = i_dmem_wdata;
            o_dmem_ready = own_ready;
            o_dmem_rdata = i_mem_rdata;
            o_dmem_valid = rsp;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cache/memory scenarios plus random traffic,
// every cycle compared against an owner/outstanding-count reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_mem_ready, i_mem_valid, i_imem_ren, i_dmem_ren, i_dmem_wen;
    logic [31:0] i_mem_rdata, i_imem_addr, i_dmem_addr, i_dmem_wdata;
    logic [31:0] o_mem_addr, o_mem_wdata, o_imem_rdata, o_dmem_rdata;
    logic        o_mem_ren, o_mem_wen, o_imem_ready, o_imem_valid, o_dmem_ready, o_dmem_valid;
    logic [1:0]  o_grant;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_ready  (i_mem_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_ren    (o_mem_ren),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_valid  (i_mem_valid),
        .i_imem_addr  (i_imem_addr),
        .i_imem_ren   (i_imem_ren),
        .o_imem_ready (o_imem_ready),
        .o_imem_rdata (o_imem_rdata),
        .o_imem_valid (o_imem_valid),
        .i_dmem_addr  (i_dmem_addr),
        .i_dmem_ren   (i_dmem_ren),
        .i_dmem_wen   (i_dmem_wen),
        .i_dmem_wdata (i_dmem_wdata),
        .o_dmem_ready (o_dmem_ready),
        .o_dmem_rdata (o_dmem_rdata),
        .o_dmem_valid (o_dmem_valid),
        .o_grant      (o_grant)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // reference model: owner 0=none 1=icache 2=dcache, reads in flight
    int m_own, m_out, m_last;
    int n_own, n_out, n_last;
    int cyc = 0;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
    logic        e_ren, e_wen, e_irdy, e_drdy, e_iv, e_dv;
    logic [1:0]  e_grant;

    task automatic model_comb();
        bit room;
        room     = (m_out < 4);
        e_grant  = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        e_addr   = (m_own == 1) ? i_imem_addr : (m_own == 2) ? i_dmem_addr : 32'h0;
        e_ren    = room && ((m_own == 1) ? i_imem_ren : (m_own == 2) ? i_dmem_ren : 1'b0);
        e_wen    = room && (m_own == 2) && i_dmem_wen;
        e_wdata  = (m_own == 2) ? i_dmem_wdata : 32'h0;
        e_irdy   = (m_own == 1) && i_mem_ready && room;
        e_drdy   = (m_own == 2) && i_mem_ready && room;
        e_iv     = (m_own == 1) && i_mem_valid && (m_out > 0);
        e_dv     = (m_own == 2) && i_mem_valid && (m_out > 0);
        e_irdata = (m_own == 1) ? i_mem_rdata : 32'h0;
        e_drdata = (m_own == 2) ? i_mem_rdata : 32'h0;
    endtask

    task automatic model_next();
        bit ri, rd, busy;
        int acc, rsp, pick;
        ri   = i_imem_ren;
        rd   = i_dmem_ren || i_dmem_wen;
        busy = (m_own == 1) ? ri : (m_own == 2) ? rd : 1'b0;
        acc  = ((e_irdy && i_imem_ren) || (e_drdy && i_dmem_ren)) ? 1 : 0;
        rsp  = (i_mem_valid && m_out > 0) ? 1 : 0;
        n_out  = m_out + acc - rsp;
        n_own  = m_own;
        n_last = m_last;
        if (m_own == 0 || (!busy && m_out == 0 && !i_mem_valid)) begin
            if (ri && rd)  pick = (m_last == 1) ? 2 : 1;
            else if (ri)   pick = 1;
            else if (rd)   pick = 2;
            else           pick = 0;
            n_own = pick;
            if (pick != 0) n_last = pick;
        end
    endtask

    // cache and memory agents
    bit          agent_on, hold, d_wr, rr;
    int          i_left, d_left, i_pend, d_pend, lat, i_bursts, d_bursts;
    logic [31:0] i_addr, d_addr, d_wdata;
    int          mq_due[$];
    logic [31:0] mq_addr[$];
    int          mq_own[$];

    // observations of the DUT
    logic [31:0] obs_rd[$];
    logic [1:0]  g_log[$];
    int          n_wr, n_iv, n_dv;
    logic [31:0] last_wdata, last_waddr;

    task automatic clear_obs();
        obs_rd.delete();
        g_log.delete();
        n_wr = 0;
        n_iv = 0;
        n_dv = 0;
        last_wdata = 32'h0;
        last_waddr = 32'h0;
    endtask

    task automatic drive_agents();
        if (rr) begin
            if (i_left == 0 && i_pend == 0 && m_own != 1 && i_bursts > 0) begin
                i_left = 4;
                i_bursts--;
            end
            if (d_left == 0 && d_pend == 0 && m_own != 2 && d_bursts > 0) begin
                d_left = 4;
                d_bursts--;
            end
        end
        i_imem_ren   = (i_left > 0);
        i_imem_addr  = (i_left > 0) ? i_addr : 32'h0;
        i_dmem_ren   = (d_left > 0) && !d_wr;
        i_dmem_wen   = (d_left > 0) && d_wr;
        i_dmem_addr  = (d_left > 0) ? d_addr : 32'h0;
        i_dmem_wdata = (d_left > 0 && d_wr) ? d_wdata : 32'h0;
        i_mem_valid  = !hold && (mq_due.size() > 0) && (mq_due[0] <= cyc);
        i_mem_rdata  = i_mem_valid ? (mq_addr[0] ^ 32'h5A5A_0000) : 32'h0;
    endtask

    task automatic agent_update();
        int who;
        if (i_mem_valid && m_out > 0 && mq_own.size() > 0) begin
            who = mq_own.pop_front();
            void'(mq_due.pop_front());
            void'(mq_addr.pop_front());
            if (who == 1) i_pend--;
            else          d_pend--;
        end
        if (i_imem_ren && e_irdy) begin
            mq_due.push_back(cyc + lat);
            mq_addr.push_back(i_imem_addr);
            mq_own.push_back(1);
            i_pend++;
            i_left--;
            i_addr += 4;
        end
        if (i_dmem_ren && e_drdy) begin
            mq_due.push_back(cyc + lat);
            mq_addr.push_back(i_dmem_addr);
            mq_own.push_back(2);
            d_pend++;
            d_left--;
            d_addr += 4;
        end
        if (i_dmem_wen && e_drdy) begin
            d_left--;
            d_addr += 4;
        end
    endtask

    // one clock cycle: entered and left at a falling edge with inputs applied
    task automatic step();
        if (!rst_n) begin
            m_own  = 0;
            m_out  = 0;
            m_last = 1;
        end
        #1;
        model_comb();
        check("grant",      {30'h0, o_grant}, {30'h0, e_grant});
        check("mem_addr",   o_mem_addr, e_addr);
        check("mem_ren",    o_mem_ren, e_ren);
        check("mem_wen",    o_mem_wen, e_wen);
        check("mem_wdata",  o_mem_wdata, e_wdata);
        check("imem_ready", o_imem_ready, e_irdy);
        check("imem_valid", o_imem_valid, e_iv);
        check("imem_rdata", o_imem_rdata, e_irdata);
        check("dmem_ready", o_dmem_ready, e_drdy);
        check("dmem_valid", o_dmem_valid, e_dv);
        check("dmem_rdata", o_dmem_rdata, e_drdata);
        g_log.push_back(o_grant);
        if (o_mem_ren && i_mem_ready) obs_rd.push_back(o_mem_addr);
        if (o_mem_wen && i_mem_ready) begin
            n_wr++;
            last_wdata = o_mem_wdata;
            last_waddr = o_mem_addr;
        end
        if (o_imem_valid) n_iv++;
        if (o_dmem_valid) n_dv++;
        model_next();
        if (agent_on && rst_n) agent_update();
        @(posedge clk);
        if (rst_n) begin
            m_own  = n_own;
            m_out  = n_out;
            m_last = n_last;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_agents(input int n);
        for (int k = 0; k < n; k++) begin
            drive_agents();
            step();
        end
    endtask

    task automatic clear_agents();
        agent_on = 1'b0; hold = 1'b0; d_wr = 1'b0; rr = 1'b0;
        i_left = 0; d_left = 0; i_pend = 0; d_pend = 0;
        i_bursts = 0; d_bursts = 0; lat = 2;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mq_due.delete(); mq_addr.delete(); mq_own.delete();
    endtask

    task automatic zero_inputs();
        i_mem_ready = 1'b1; i_mem_valid = 1'b0; i_mem_rdata = 32'h0;
        i_imem_ren = 1'b0; i_imem_addr = 32'h0;
        i_dmem_ren = 1'b0; i_dmem_wen = 1'b0; i_dmem_addr = 32'h0; i_dmem_wdata = 32'h0;
    endtask

    // outputs must stay 0 under reset even with every request input busy
    task automatic do_reset();
        clear_agents();
        rst_n = 1'b0;
        i_mem_ready = 1'b1; i_mem_valid = 1'b1; i_mem_rdata = $urandom;
        i_imem_ren = 1'b1; i_imem_addr = $urandom;
        i_dmem_ren = 1'b1; i_dmem_wen = 1'b1; i_dmem_addr = $urandom; i_dmem_wdata = $urandom;
        step();
        step();
        zero_inputs();
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic test_icache_fill();
        do_reset();
        agent_on = 1'b1; i_left = 4; i_addr = 32'h100;
        run_agents(1);
        check("t1_grant_latency", {30'h0, o_grant}, 32'h1);
        run_agents(15);
        check("t1_nreads", obs_rd.size(), 4);
        if (obs_rd.size() == 4)
            for (int k = 0; k < 4; k++) check("t1_addr", obs_rd[k], 32'h100 + 32'(4 * k));
        check("t1_nvalid", n_iv, 4);
        check("t1_grant_idle", {30'h0, o_grant}, 32'h0);
    endtask

    task automatic test_tie();
        int f, l;
        do_reset();
        agent_on = 1'b1;
        i_left = 4; i_addr = 32'h200;
        d_left = 4; d_addr = 32'h400;
        run_agents(30);
        f = -1; l = -1;
        foreach (g_log[k]) begin
            if (g_log[k] != 2'b00 && f < 0) f = k;
            if (g_log[k] == 2'b10) l = k;
        end
        check("t2_first_found", (f >= 0), 1);
        if (f >= 0) check("t2_first_owner", {30'h0, g_log[f]}, 32'h2);
        check("t2_d_found", (l >= 0 && l + 1 < g_log.size()), 1);
        if (l >= 0 && l + 1 < g_log.size()) check("t2_direct_handoff", {30'h0, g_log[l+1]}, 32'h1);
        check("t2_nreads", obs_rd.size(), 8);
        if (obs_rd.size() == 8) begin
            check("t2_d_first", obs_rd[0], 32'h400);
            check("t2_i_after", obs_rd[4], 32'h200);
        end
        check("t2_ivalid", n_iv, 4);
        check("t2_dvalid", n_dv, 4);
    endtask

    task automatic test_saturation();
        do_reset();
        agent_on = 1'b1; hold = 1'b1; d_left = 6; d_addr = 32'h400;
        run_agents(8);
        check("t3_accepted", obs_rd.size(), 4);
        check("t3_ready_blocked", o_dmem_ready, 1'b0);
        check("t3_ren_blocked", o_mem_ren, 1'b0);
        hold = 1'b0;
        run_agents(1);
        check("t3_ready_back", o_dmem_ready, 1'b1);
        run_agents(25);
        check("t3_total_reads", obs_rd.size(), 6);
        check("t3_dvalid", n_dv, 6);
        check("t3_grant_idle", {30'h0, o_grant}, 32'h0);
    endtask

    task automatic test_write();
        do_reset();
        agent_on = 1'b1; d_wr = 1'b1; d_left = 1; d_addr = 32'h80; d_wdata = 32'hDEAD_BEEF;
        run_agents(2);
        check("t4_nwrites", n_wr, 1);
        check("t4_wdata", last_wdata, 32'hDEAD_BEEF);
        check("t4_waddr", last_waddr, 32'h80);
        check("t4_still_granted", {30'h0, o_grant}, 32'h2);
        run_agents(1);
        check("t4_released", {30'h0, o_grant}, 32'h0);
        check("t4_no_reads", obs_rd.size(), 0);
    endtask

    task automatic test_round_robin();
        logic [1:0] seq[$];
        int f, l, zeros;
        do_reset();
        agent_on = 1'b1; rr = 1'b1; i_bursts = 3; d_bursts = 3;
        i_addr = 32'h1000; d_addr = 32'h2000;
        run_agents(90);
        f = -1; l = -1; zeros = 0;
        foreach (g_log[k]) if (g_log[k] != 2'b00) begin
            if (f < 0) f = k;
            l = k;
        end
        if (f >= 0) begin
            for (int k = f; k <= l; k++) begin
                if (g_log[k] == 2'b00) zeros++;
                else if (seq.size() == 0 || seq[$] != g_log[k]) seq.push_back(g_log[k]);
            end
        end
        check("t5_bursts", seq.size(), 6);
        check("t5_no_idle_gap", zeros, 0);
        foreach (seq[k]) check("t5_alternate", {30'h0, seq[k]}, (k % 2 == 0) ? 32'h2 : 32'h1);
        check("t5_reads", obs_rd.size(), 24);
    endtask

    task automatic test_reset_mid_fill();
        int guard;
        do_reset();
        agent_on = 1'b1; lat = 10; i_left = 4; i_addr = 32'h300;
        guard = 0;
        while (i_left > 2 && guard < 20) begin
            run_agents(1);
            guard++;
        end
        check("t6_two_accepted", obs_rd.size(), 2);
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", {30'h0, o_grant}, 32'h0);
        check("t6_async_ren", o_mem_ren, 1'b0);
        check("t6_async_addr", o_mem_addr, 32'h0);
        check("t6_async_ready", o_imem_ready, 1'b0);
        @(negedge clk);
        step();
        clear_agents();
        zero_inputs();
        rst_n = 1'b1;
        i_mem_valid = 1'b1; i_mem_rdata = 32'h1234_5678;
        step();
        check("t6_stray_valid", o_imem_valid, 1'b0);
        i_mem_valid = 1'b0;
        step();
        check("t6_grant_stays_idle", {30'h0, o_grant}, 32'h0);
    endtask

    task automatic test_random(input int n);
        do_reset();
        for (int k = 0; k < n; k++) begin
            i_mem_ready  = ($urandom_range(0, 9) < 7);
            i_mem_valid  = ($urandom_range(0, 9) < 3);
            i_mem_rdata  = $urandom;
            i_imem_ren   = ($urandom_range(0, 9) < 6);
            i_imem_addr  = $urandom & 32'hFFFF_FFFC;
            i_dmem_ren   = ($urandom_range(0, 9) < 4);
            i_dmem_wen   = ($urandom_range(0, 9) < 2);
            i_dmem_addr  = $urandom & 32'hFFFF_FFFC;
            i_dmem_wdata = $urandom;
            step();
        end
    endtask

    initial begin
        clear_agents();
        zero_inputs();
        clear_obs();
        @(negedge clk);
        test_icache_fill();
        test_tie();
        test_saturation();
        test_write();
        test_round_robin();
        test_reset_mid_fill();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
